// File: rtl/avst_adt_pkg.sv
// Shared constants and elaboration helpers for the ready-latency adapter buffer.
package avst_adt_pkg;

    localparam int MAX_READY_LATENCY = 3;

    // A depth is legal when it is a power of two and can hold every beat already in flight.
    function automatic bit depth_legal(input int depth, input int latency);
        return (depth >= 1) && ((depth & (depth - 1)) == 0) &&
               (latency >= 0) && (latency <= MAX_READY_LATENCY) &&
               (depth >= latency + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/avst_adt_ram.sv
// Buffer storage: one synchronous write port and one asynchronous read port, not reset.
module avst_adt_ram
    import avst_adt_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int PW     = ptr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/avst_timing_adt_buf.sv
// Ready-latency adapter: absorbs an upstream with IN_READY_LATENCY into a latency-0 FWFT output.
// Optional sticky overflow flag and drop message under macro AVST_TADT_OVF_FLAG_EN.
module avst_timing_adt_buf
    import avst_adt_pkg::*;
#(
    parameter int DATA_W           = 8,
    parameter int DEPTH            = 4,
    parameter int IN_READY_LATENCY = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] fill_level
`ifdef AVST_TADT_OVF_FLAG_EN
    ,
    output logic                       overflow
`endif
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 1 - IN_READY_LATENCY);

    if (!depth_legal(DEPTH, IN_READY_LATENCY) || DATA_W < 1 || DATA_W > 256) begin : g_bad_params
        $error("avst_timing_adt_buf: illegal DATA_W/DEPTH/IN_READY_LATENCY combination");
    end

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, push, pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Handshake: upstream beats count whenever in_valid=1 (in_ready is advisory, DEPTH-1-L
    // entries ahead); downstream beat transfers when out_valid=1 and out_ready=1.
    assign full      = (count == FULL_CNT);
    assign pop       = out_valid & out_ready;
    assign push      = in_valid & (~full | pop);
    assign out_valid = (count != '0);
    assign in_ready  = (count <= READY_MAX);
    assign fill_level = count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    avst_adt_ram #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_ram (
        .clk  (clk),
        .we   (push),
        .waddr(wr_ptr),
        .wdata(in_data),
        .raddr(rd_ptr),
        .rdata(out_data)
    );

`ifdef AVST_TADT_OVF_FLAG_EN
    logic ovf_evt;
    assign ovf_evt = in_valid & full & ~pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (ovf_evt) begin
            overflow <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && ovf_evt) begin
            $display("avst_timing_adt_buf: overflow, beat 0x%0h dropped at %0t", in_data, $time);
        end
    end
`endif
`endif

endmodule

// File: tb/tb_avst_timing_adt_buf.sv
// Directed bench for avst_timing_adt_buf: latency-0 and latency-2 instances, both DEPTH=4.
module tb_avst_timing_adt_buf;

    logic       clk;
    logic       reset;

    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [7:0] a_in_data, a_out_data;
    logic [2:0] a_fill_level;
    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0] b_in_data, b_out_data;
    logic [2:0] b_fill_level;
`ifdef AVST_TADT_OVF_FLAG_EN
    logic       a_overflow, b_overflow;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    avst_timing_adt_buf #(.DATA_W(8), .DEPTH(4), .IN_READY_LATENCY(0)) u_l0 (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
        .fill_level(a_fill_level)
`ifdef AVST_TADT_OVF_FLAG_EN
        , .overflow(a_overflow)
`endif
    );

    avst_timing_adt_buf #(.DATA_W(8), .DEPTH(4), .IN_READY_LATENCY(2)) u_l2 (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
        .fill_level(b_fill_level)
`ifdef AVST_TADT_OVF_FLAG_EN
        , .overflow(b_overflow)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_in_valid = 0; a_in_data = 0; a_out_ready = 0;
        b_in_valid = 0; b_in_data = 0; b_out_ready = 0;
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_a_out_valid got %b exp 0", a_out_valid); end
        checks++; if (a_fill_level !== 3'd0) begin errors++; $display("FAIL reset_a_fill got %0d exp 0", a_fill_level); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_a_in_ready got %b exp 1", a_in_ready); end
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL reset_b_out_valid got %b exp 0", b_out_valid); end
        checks++; if (b_fill_level !== 3'd0) begin errors++; $display("FAIL reset_b_fill got %0d exp 0", b_fill_level); end
        checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL reset_b_in_ready got %b exp 1", b_in_ready); end
`ifdef AVST_TADT_OVF_FLAG_EN
        checks++; if (a_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", a_overflow); end
`endif
        reset = 1'b0;
        cycle();
    endtask

    task automatic test_back_to_back();
        a_out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            a_in_valid = (k < 8);
            a_in_data  = 8'(k + 1);
            cycle();
            if (k < 8) begin
                checks++; if (a_out_valid !== 1'b1 || a_out_data !== 8'(k + 1))
                    begin errors++; $display("FAIL b2b_data[%0d] got v=%b d=%h exp v=1 d=%h", k, a_out_valid, a_out_data, 8'(k + 1)); end
                checks++; if (a_fill_level !== 3'd1)
                    begin errors++; $display("FAIL b2b_fill[%0d] got %0d exp 1", k, a_fill_level); end
            end else begin
                checks++; if (a_out_valid !== 1'b0 || a_fill_level !== 3'd0)
                    begin errors++; $display("FAIL b2b_empty got v=%b fill=%0d exp v=0 fill=0", a_out_valid, a_fill_level); end
            end
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b0;
    endtask

    task automatic test_latency2();
        logic r1, r2, send;
        int   exp_cnt, nsent;
        r1 = 1'b1; r2 = 1'b1; exp_cnt = 0; nsent = 0;
        b_out_ready = 1'b0;
        for (int t = 0; t < 8; t++) begin
            checks++; if (b_fill_level !== 3'(exp_cnt) || b_in_ready !== (exp_cnt <= 1))
                begin errors++; $display("FAIL lat2_ready[%0d] got fill=%0d rdy=%b exp fill=%0d rdy=%b", t, b_fill_level, b_in_ready, exp_cnt, (exp_cnt <= 1)); end
            send = r2;
            r2 = r1;
            r1 = b_in_ready;
            b_in_valid = send;
            b_in_data  = 8'(8'h10 + nsent);
            if (send) begin
                nsent++;
                if (exp_cnt < 4) exp_cnt++;
            end
            cycle();
        end
        b_in_valid = 1'b0;
        checks++; if (nsent !== 4 || b_fill_level !== 3'd4)
            begin errors++; $display("FAIL lat2_stored got sent=%0d fill=%0d exp 4 4", nsent, b_fill_level); end
`ifdef AVST_TADT_OVF_FLAG_EN
        checks++; if (b_overflow !== 1'b0) begin errors++; $display("FAIL lat2_overflow got %b exp 0", b_overflow); end
`endif
        b_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (b_out_valid !== 1'b1 || b_out_data !== 8'(8'h10 + i))
                begin errors++; $display("FAIL lat2_drain[%0d] got v=%b d=%h exp d=%h", i, b_out_valid, b_out_data, 8'(8'h10 + i)); end
            cycle();
        end
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL lat2_empty got %b exp 0", b_out_valid); end
        b_out_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        a_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1; a_in_data = 8'(8'h21 + i);
            cycle();
        end
        a_in_valid = 1'b0;
        checks++; if (a_fill_level !== 3'd4 || a_in_ready !== 1'b0)
            begin errors++; $display("FAIL full_state got fill=%0d rdy=%b exp 4 0", a_fill_level, a_in_ready); end
        a_in_valid = 1'b1; a_in_data = 8'h25; a_out_ready = 1'b1;
        checks++; if (a_out_data !== 8'h21) begin errors++; $display("FAIL full_head got %h exp 21", a_out_data); end
        cycle();
        a_in_valid = 1'b0;
        checks++; if (a_fill_level !== 3'd4 || a_out_data !== 8'h22)
            begin errors++; $display("FAIL full_pushpop got fill=%0d d=%h exp 4 22", a_fill_level, a_out_data); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (a_out_data !== 8'(8'h22 + i))
                begin errors++; $display("FAIL full_drain[%0d] got %h exp %h", i, a_out_data, 8'(8'h22 + i)); end
            cycle();
        end
        a_out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        a_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1; a_in_data = 8'(8'h31 + i);
            cycle();
        end
        a_in_data = 8'hAA;
        cycle();
        a_in_valid = 1'b0;
        checks++; if (a_fill_level !== 3'd4 || a_out_data !== 8'h31)
            begin errors++; $display("FAIL ovf_drop got fill=%0d d=%h exp 4 31", a_fill_level, a_out_data); end
`ifdef AVST_TADT_OVF_FLAG_EN
        checks++; if (a_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", a_overflow); end
`endif
        a_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (a_out_data !== 8'(8'h31 + i))
                begin errors++; $display("FAIL ovf_drain[%0d] got %h exp %h", i, a_out_data, 8'(8'h31 + i)); end
            cycle();
        end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %b exp 0", a_out_valid); end
`ifdef AVST_TADT_OVF_FLAG_EN
        checks++; if (a_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", a_overflow); end
`endif
        a_out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        a_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_in_valid = 1'b1; a_in_data = 8'(8'h41 + i);
            cycle();
        end
        a_in_valid = 1'b0;
        checks++; if (a_fill_level !== 3'd3) begin errors++; $display("FAIL mid_prefill got %0d exp 3", a_fill_level); end
        #2 reset = 1'b1;
        #1;
        checks++; if (a_out_valid !== 1'b0 || a_fill_level !== 3'd0 || a_in_ready !== 1'b1)
            begin errors++; $display("FAIL mid_async got v=%b fill=%0d rdy=%b exp 0 0 1", a_out_valid, a_fill_level, a_in_ready); end
`ifdef AVST_TADT_OVF_FLAG_EN
        checks++; if (a_overflow !== 1'b0) begin errors++; $display("FAIL mid_ovf_clear got %b exp 0", a_overflow); end
`endif
        @(negedge clk);
        reset = 1'b0;
        a_in_valid = 1'b1; a_in_data = 8'h55; a_out_ready = 1'b1;
        cycle();
        a_in_valid = 1'b0;
        checks++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h55 || a_fill_level !== 3'd1)
            begin errors++; $display("FAIL mid_first got v=%b d=%h fill=%0d exp 1 55 1", a_out_valid, a_out_data, a_fill_level); end
        cycle();
        checks++; if (a_fill_level !== 3'd0) begin errors++; $display("FAIL mid_drain got %0d exp 0", a_fill_level); end
        a_out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        int sent, recv, cyc;
        logic [7:0] exp_d;
        sent = 0; recv = 0; cyc = 0;
        exp_q.delete();
        while (recv < 20 && cyc < 300) begin
            checks++; if (a_fill_level !== 3'(exp_q.size()))
                begin errors++; $display("FAIL wrap_fill[%0d] got %0d exp %0d", cyc, a_fill_level, exp_q.size()); end
            a_out_ready = 1'($urandom_range(0, 1));
            if (a_out_valid && a_out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL wrap_extra got %h exp none", a_out_data);
                end else begin
                    exp_d = exp_q.pop_front();
                    if (a_out_data !== exp_d) begin errors++; $display("FAIL wrap_data[%0d] got %h exp %h", recv, a_out_data, exp_d); end
                end
                recv++;
            end
            a_in_valid = (sent < 20) && a_in_ready;
            a_in_data  = 8'(8'h60 + sent);
            if (a_in_valid) begin
                exp_q.push_back(a_in_data);
                sent++;
            end
            cycle();
            cyc++;
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b0;
        checks++; if (recv !== 20 || exp_q.size() !== 0)
            begin errors++; $display("FAIL wrap_count got recv=%0d left=%0d exp 20 0", recv, exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_latency2();
        test_full_push_pop();
        test_overflow();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
